// File: rtl/pdfd_rx_symbol_buffer_pkg.sv
// Shared types and constants for the PDFD receive symbol buffer.
//   pam5_sym_t  : signed 3-bit PAM5 decision
//   rx_word_t   : four lanes (A..D) plus an illegal-word flag
//   rx_state_t  : lock state machine encoding
//   unpack_word : splits a packed 12-bit PDFD word into lanes and flags legality
package pdfd_pkg;

    typedef logic signed [2:0] pam5_sym_t;

    typedef struct packed {
        pam5_sym_t sym_a;
        pam5_sym_t sym_b;
        pam5_sym_t sym_c;
        pam5_sym_t sym_d;
        logic      illegal;
    } rx_word_t;

    localparam pam5_sym_t PAM5_MIN = -3'sd2;
    localparam pam5_sym_t PAM5_MAX = 3'sd2;

    localparam int unsigned LANE_A_LSB = 9;
    localparam int unsigned LANE_B_LSB = 6;
    localparam int unsigned LANE_C_LSB = 3;
    localparam int unsigned LANE_D_LSB = 0;

    typedef enum logic {
        WARMUP = 1'b0,
        RUN    = 1'b1
    } rx_state_t;

    function automatic logic sym_legal(pam5_sym_t s);
        return (s >= PAM5_MIN) && (s <= PAM5_MAX);
    endfunction

    function automatic rx_word_t unpack_word(logic [11:0] d);
        rx_word_t w;
        w.sym_a   = pam5_sym_t'(d[LANE_A_LSB +: 3]);
        w.sym_b   = pam5_sym_t'(d[LANE_B_LSB +: 3]);
        w.sym_c   = pam5_sym_t'(d[LANE_C_LSB +: 3]);
        w.sym_d   = pam5_sym_t'(d[LANE_D_LSB +: 3]);
        w.illegal = ~(sym_legal(w.sym_a) & sym_legal(w.sym_b) &
                      sym_legal(w.sym_c) & sym_legal(w.sym_d));
        return w;
    endfunction

endpackage

// File: rtl/pdfd_rx_symbol_buffer_if.sv
// Bus between the PDFD, the symbol buffer and the PCS receive decoder.
//   io_rxData/io_rxValid : packed PDFD decisions and strobe
//   io_flush             : synchronous flush request
//   io_out_*             : head-of-FIFO word with valid/ready handshake
//   io_locked, io_count, io_overflow, io_err_count : status
// slave = the buffer, master = the surrounding logic.
interface pdfd_rx_symbol_buffer_if
    import pdfd_pkg::*;
#(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned ERR_W = 16
);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [11:0]      io_rxData;
    logic             io_rxValid;
    logic             io_flush;
    logic             io_out_ready;
    logic             io_out_valid;
    pam5_sym_t        io_out_sym_0;
    pam5_sym_t        io_out_sym_1;
    pam5_sym_t        io_out_sym_2;
    pam5_sym_t        io_out_sym_3;
    logic             io_out_illegal;
    logic             io_locked;
    logic [CNT_W-1:0] io_count;
    logic             io_overflow;
    logic [ERR_W-1:0] io_err_count;

    modport slave (
        input  io_rxData, io_rxValid, io_flush, io_out_ready,
        output io_out_valid, io_out_sym_0, io_out_sym_1, io_out_sym_2,
               io_out_sym_3, io_out_illegal, io_locked, io_count,
               io_overflow, io_err_count
    );

    modport master (
        output io_rxData, io_rxValid, io_flush, io_out_ready,
        input  io_out_valid, io_out_sym_0, io_out_sym_1, io_out_sym_2,
               io_out_sym_3, io_out_illegal, io_locked, io_count,
               io_overflow, io_err_count
    );
endinterface

// File: rtl/pdfd_sync_fifo.sv
// Generic synchronous FIFO.
//   clock, reset (sync, active-low), clear (sync empty)
//   push/din  : write, accepted when not full or when a pop happens the same cycle
//   pop/dout  : read, ignored while empty; dout shows the head word
//   full, empty, count : occupancy status
module pdfd_sync_fifo #(
    parameter int unsigned WIDTH = 13,
    parameter int unsigned DEPTH = 8
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           clear,
    input  logic                           push,
    input  logic [WIDTH-1:0]               din,
    input  logic                           pop,
    output logic [WIDTH-1:0]               dout,
    output logic                           full,
    output logic                           empty,
    output logic [$clog2(DEPTH+1)-1:0]     count
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             pop_ok;
    logic             push_ok;

    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(DEPTH));
    assign pop_ok  = pop & ~empty;
    assign push_ok = push & (~full | pop_ok);
    assign dout    = mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clock) begin
        if (!reset || clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CNT_W'(push_ok) - CNT_W'(pop_ok);
        end
    end

    always_ff @(posedge clock) begin
        if (reset && !clear && push_ok) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/pdfd_rx_symbol_buffer.sv
// PDFD receive symbol buffer.
// Unpacks the four PAM5 decisions from each PDFD word, discards the PDFD
// warm-up output, checks symbol legality, tracks lock and buffers words in a
// FIFO toward the PCS receive decoder.
//   clock, reset : single clock, synchronous active-low reset
//   bus          : pdfd_rx_symbol_buffer_if.slave (data in, handshake out, status)
module pdfd_rx_symbol_buffer
    import pdfd_pkg::*;
#(
    parameter int unsigned DEPTH   = 8,
    parameter int unsigned SKIP    = 15,
    parameter int unsigned MAX_BAD = 4,
    parameter int unsigned ERR_W   = 16
) (
    input  logic                    clock,
    input  logic                    reset,
    pdfd_rx_symbol_buffer_if.slave  bus
);
    localparam int unsigned SKIP_W = $clog2(SKIP + 1);
    localparam int unsigned BAD_W  = $clog2(MAX_BAD + 1);

    rx_state_t        state;
    rx_state_t        state_nxt;
    logic [SKIP_W-1:0] skip_cnt;
    logic [BAD_W-1:0]  bad_cnt;
    logic [ERR_W-1:0]  err_cnt;
    logic              overflow;

    rx_word_t in_word;
    rx_word_t head;
    logic     fifo_full;
    logic     fifo_empty;
    logic     warm_word;
    logic     run_word;
    logic     skip_done;
    logic     bad_hit;
    logic     do_pop;

    assign in_word = unpack_word(bus.io_rxData);

    // A flush discards the incoming word and any pop in the same cycle.
    always_comb begin
        warm_word = bus.io_rxValid & ~bus.io_flush & (state == WARMUP);
        run_word  = bus.io_rxValid & ~bus.io_flush & (state == RUN);
        skip_done = warm_word & (skip_cnt == SKIP_W'(SKIP - 1));
        bad_hit   = run_word & in_word.illegal & (bad_cnt == BAD_W'(MAX_BAD - 1));
        do_pop    = ~fifo_empty & bus.io_out_ready & ~bus.io_flush;
    end

    always_ff @(posedge clock) begin
        if (!reset) state <= WARMUP;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (bus.io_flush) begin
            state_nxt = WARMUP;
        end else begin
            unique case (state)
                WARMUP: if (skip_done) state_nxt = RUN;
                RUN:    if (bad_hit)   state_nxt = WARMUP;
                default: state_nxt = WARMUP;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            skip_cnt <= '0;
            bad_cnt  <= '0;
            err_cnt  <= '0;
            overflow <= 1'b0;
        end else if (bus.io_flush) begin
            skip_cnt <= '0;
            bad_cnt  <= '0;
            overflow <= 1'b0;
        end else begin
            if (warm_word) skip_cnt <= skip_done ? '0 : skip_cnt + 1'b1;
            if (run_word) begin
                if (in_word.illegal) begin
                    bad_cnt <= bad_hit ? '0 : bad_cnt + 1'b1;
                    if (err_cnt != '1) err_cnt <= err_cnt + 1'b1;
                end else begin
                    bad_cnt <= '0;
                end
                // Counters above still update for a word that gets dropped here.
                if (fifo_full && !do_pop) overflow <= 1'b1;
            end
            if (bad_hit) skip_cnt <= '0;
        end
    end

    pdfd_sync_fifo #(
        .WIDTH ($bits(rx_word_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .clear (bus.io_flush),
        .push  (run_word),
        .din   (in_word),
        .pop   (do_pop),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (bus.io_count)
    );

    // Head fields read as zero while empty so stale memory never shows.
    assign bus.io_out_valid   = ~fifo_empty;
    assign bus.io_out_sym_0   = fifo_empty ? '0 : head.sym_a;
    assign bus.io_out_sym_1   = fifo_empty ? '0 : head.sym_b;
    assign bus.io_out_sym_2   = fifo_empty ? '0 : head.sym_c;
    assign bus.io_out_sym_3   = fifo_empty ? '0 : head.sym_d;
    assign bus.io_out_illegal = ~fifo_empty & head.illegal;
    assign bus.io_locked      = (state == RUN);
    assign bus.io_overflow    = overflow;
    assign bus.io_err_count   = err_cnt;

endmodule

// File: tb/tb_pdfd_rx_symbol_buffer.sv
module tb_pdfd_rx_symbol_buffer;
    import pdfd_pkg::*;

    localparam int unsigned DEPTH   = 8;
    localparam int unsigned SKIP    = 15;
    localparam int unsigned MAX_BAD = 4;
    localparam int unsigned ERR_W   = 16;

    logic clock = 1'b0;
    logic reset = 1'b0;

    pdfd_rx_symbol_buffer_if #(.DEPTH(DEPTH), .ERR_W(ERR_W)) bus ();

    pdfd_rx_symbol_buffer #(
        .DEPTH   (DEPTH),
        .SKIP    (SKIP),
        .MAX_BAD (MAX_BAD),
        .ERR_W   (ERR_W)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    // Reference model: queue of raw words plus lock bookkeeping.
    logic [11:0] m_q[$];
    bit          m_locked;
    int          m_skip;
    int          m_bad;
    bit          m_ovf;
    longint      m_err;

    function automatic int lane_val(logic [11:0] w, int k);
        logic [2:0] b;
        b = w[(3 - k) * 3 +: 3];
        return b[2] ? int'(b) - 8 : int'(b);
    endfunction

    function automatic bit word_illegal(logic [11:0] w);
        for (int k = 0; k < 4; k++) begin
            if (lane_val(w, k) < -2 || lane_val(w, k) > 2) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic logic [11:0] pack(int a, int b, int c, int d);
        return {3'(a), 3'(b), 3'(c), 3'(d)};
    endfunction

    function automatic logic [11:0] rand_legal();
        return pack(int'($urandom_range(0, 4)) - 2, int'($urandom_range(0, 4)) - 2,
                    int'($urandom_range(0, 4)) - 2, int'($urandom_range(0, 4)) - 2);
    endfunction

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge(bit rst_n, bit v, logic [11:0] d, bit f, bit rd);
        if (!rst_n) begin
            m_q.delete();
            m_locked = 0; m_skip = 0; m_bad = 0; m_ovf = 0; m_err = 0;
        end else if (f) begin
            m_q.delete();
            m_locked = 0; m_skip = 0; m_bad = 0; m_ovf = 0;
        end else begin
            if (rd && m_q.size() > 0) void'(m_q.pop_front());
            if (v) begin
                if (!m_locked) begin
                    m_skip++;
                    if (m_skip == SKIP) begin
                        m_locked = 1;
                        m_skip = 0;
                    end
                end else begin
                    if (word_illegal(d)) begin
                        if (m_err < (64'd1 << ERR_W) - 1) m_err++;
                        m_bad++;
                        if (m_bad == MAX_BAD) begin
                            m_locked = 0; m_bad = 0; m_skip = 0;
                        end
                    end else begin
                        m_bad = 0;
                    end
                    if (m_q.size() < DEPTH) m_q.push_back(d);
                    else m_ovf = 1;
                end
            end
        end
    endtask

    task automatic compare_all();
        bit          ev;
        logic [11:0] h;
        ev = (m_q.size() != 0);
        h  = ev ? m_q[0] : 12'd0;
        check("out_valid", {31'b0, bus.io_out_valid}, {31'b0, ev});
        check("sym0", {29'b0, bus.io_out_sym_0}, {29'b0, h[11:9]});
        check("sym1", {29'b0, bus.io_out_sym_1}, {29'b0, h[8:6]});
        check("sym2", {29'b0, bus.io_out_sym_2}, {29'b0, h[5:3]});
        check("sym3", {29'b0, bus.io_out_sym_3}, {29'b0, h[2:0]});
        check("out_illegal", {31'b0, bus.io_out_illegal}, {31'b0, ev && word_illegal(h)});
        check("locked", {31'b0, bus.io_locked}, {31'b0, m_locked});
        check("count", 32'(bus.io_count), 32'(m_q.size()));
        check("overflow", {31'b0, bus.io_overflow}, {31'b0, m_ovf});
        check("err_count", 32'(bus.io_err_count), 32'(m_err));
    endtask

    // Drive inputs away from the edge, advance one edge, then compare.
    task automatic step(bit v, logic [11:0] d, bit f, bit rd, bit rst_n);
        bus.io_rxValid   = v;
        bus.io_rxData    = d;
        bus.io_flush     = f;
        bus.io_out_ready = rd;
        reset            = rst_n;
        @(posedge clock);
        model_edge(rst_n, v, d, f, rd);
        #1;
        compare_all();
    endtask

    task automatic relock(bit rd);
        for (int i = 0; i < int'(SKIP); i++) step(1, rand_legal(), 0, rd, 1);
    endtask

    initial begin
        bus.io_rxValid = 0; bus.io_rxData = '0; bus.io_flush = 0; bus.io_out_ready = 0;
        m_locked = 0; m_skip = 0; m_bad = 0; m_ovf = 0; m_err = 0;

        // Reset
        step(0, '0, 0, 0, 0);
        step(0, '0, 0, 0, 0);
        check("reset_count", 32'(bus.io_count), 32'd0);
        check("reset_valid", {31'b0, bus.io_out_valid}, 32'd0);

        // Warm-up discard
        for (int i = 1; i <= 15; i++) begin
            step(1, pack(1, 0, -1, 2), 0, 0, 1);
            check("warmup_valid", {31'b0, bus.io_out_valid}, 32'd0);
            check("warmup_lock", {31'b0, bus.io_locked}, (i == 15) ? 32'd1 : 32'd0);
        end
        step(1, pack(-2, -1, 0, 1), 0, 0, 1);
        check("first_valid", {31'b0, bus.io_out_valid}, 32'd1);
        check("first_sym0", {29'b0, bus.io_out_sym_0}, 32'h6);
        check("first_sym3", {29'b0, bus.io_out_sym_3}, 32'h1);
        check("first_illegal", {31'b0, bus.io_out_illegal}, 32'd0);
        step(0, '0, 0, 1, 1);

        // Backpressure and full
        for (int i = 0; i < 10; i++) step(1, rand_legal(), 0, 0, 1);
        check("bp_count", 32'(bus.io_count), 32'd8);
        check("bp_overflow", {31'b0, bus.io_overflow}, 32'd1);
        for (int i = 0; i < 8; i++) step(0, '0, 0, 1, 1);
        check("bp_drained", 32'(bus.io_count), 32'd0);

        // Full push+pop
        step(0, '0, 1, 0, 1);
        relock(0);
        for (int i = 0; i < 8; i++) step(1, rand_legal(), 0, 0, 1);
        for (int i = 0; i < 6; i++) begin
            step(1, rand_legal(), 0, 1, 1);
            check("pp_count", 32'(bus.io_count), 32'd8);
        end
        check("pp_overflow", {31'b0, bus.io_overflow}, 32'd0);
        for (int i = 0; i < 8; i++) step(0, '0, 0, 1, 1);

        // Illegal words and lock loss
        for (int i = 0; i < 3; i++) begin
            step(1, pack(int'($urandom_range(0, 4)) - 2, 3, 0, 1), 0, 1, 1);
            check("illB_flag", {31'b0, bus.io_out_illegal}, 32'd1);
        end
        step(1, rand_legal(), 0, 1, 1);
        check("legal_flag", {31'b0, bus.io_out_illegal}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            step(1, pack(1, -1, int'($urandom_range(0, 4)) - 2, -4), 0, 1, 1);
            check("illD_flag", {31'b0, bus.io_out_illegal}, 32'd1);
            check("illD_lock", {31'b0, bus.io_locked}, (i == 3) ? 32'd0 : 32'd1);
        end
        check("ill_err", 32'(bus.io_err_count), 32'd7);
        for (int i = 1; i <= 15; i++) begin
            step(1, rand_legal(), 0, 1, 1);
            check("relock_discard", {31'b0, bus.io_out_valid}, 32'd0);
        end
        check("relock_lock", {31'b0, bus.io_locked}, 32'd1);

        // Flush
        for (int i = 0; i < 10; i++) step(1, rand_legal(), 0, 0, 1);
        for (int i = 0; i < 3; i++) step(0, '0, 0, 1, 1);
        check("pre_flush_count", 32'(bus.io_count), 32'd5);
        check("pre_flush_ovf", {31'b0, bus.io_overflow}, 32'd1);
        step(1, pack(3, 3, 3, 3), 1, 1, 1);
        check("flush_count", 32'(bus.io_count), 32'd0);
        check("flush_ovf", {31'b0, bus.io_overflow}, 32'd0);
        check("flush_lock", {31'b0, bus.io_locked}, 32'd0);
        check("flush_err", 32'(bus.io_err_count), 32'd7);

        // Reset mid-operation
        relock(0);
        for (int i = 0; i < 3; i++) step(1, rand_legal(), 0, 0, 1);
        step(1, rand_legal(), 0, 1, 0);
        check("mid_reset_count", 32'(bus.io_count), 32'd0);
        check("mid_reset_err", 32'(bus.io_err_count), 32'd0);
        for (int i = 1; i <= 15; i++) begin
            step(1, rand_legal(), 0, 0, 1);
            check("mid_reset_warm", {31'b0, bus.io_locked}, (i == 15) ? 32'd1 : 32'd0);
        end

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            logic [11:0] d;
            d = ($urandom_range(0, 1) != 0) ? rand_legal() : 12'($urandom);
            step($urandom_range(0, 3) != 0, d, $urandom_range(0, 99) == 0,
                 $urandom_range(0, 2) != 0, $urandom_range(0, 299) != 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
